// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// the term-counter width derivation.
package prod_accum_pkg;

  // ACC collects products, HOLD presents the finished sum downstream.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Counter must hold values 0..n_terms inclusive.
  function automatic int cnt_width(input int n_terms);
    return $clog2(n_terms + 1);
  endfunction

endpackage

// File: rtl/prod_accum.sv
// Sequential accumulator behind the 8x8 shift-and-add multiplier. Sums up to
// N_TERMS unsigned products (fewer if in_last is seen) into an ACC_W-bit
// register and presents sum, term count and a sticky wrap flag over
// valid/ready. One bubble per sum: in_ready is low for every HOLD cycle.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int P_W     = 16,
  parameter int ACC_W   = 24,
  parameter int N_TERMS = 8,
  localparam int CNT_W  = cnt_width(N_TERMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Unsigned wrap-around add; the extra MSB of the result is the carry out
  // of ACC_W, which feeds the sticky overflow flag.
  function automatic logic [ACC_W:0] add_wrap(input logic [ACC_W-1:0] a,
                                               input logic [P_W-1:0]   b);
    logic [ACC_W:0] b_ext;
    b_ext          = '0;
    b_ext[P_W-1:0] = b;
    return {1'b0, a} + b_ext;
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             accept;
  logic             release_out;
  logic             last_term;
  logic [ACC_W:0]   sum_ext;

  // Handshake decode and the candidate sum for this cycle's product.
  always_comb begin
    accept      = in_valid && (state == ST_ACC);
    release_out = out_ready && (state == ST_HOLD);
    last_term   = in_last || (cnt == CNT_W'(N_TERMS - 1));
    sum_ext     = add_wrap(acc, in_prod);
  end

  // Next-state: a terminating accept moves to HOLD, a taken result returns to ACC.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (accept && last_term) state_nxt = ST_HOLD;
      ST_HOLD: if (release_out)         state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  // State register; reset drops any sum in progress or on display.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator, term counter and sticky wrap flag. They clear when the
  // result is taken so the next sum starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum_ext[ACC_W-1:0];
      cnt <= cnt + CNT_W'(1);
      ovf <= ovf | sum_ext[ACC_W];
    end else if (release_out) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

  // Handshake outputs are decoded from state only; data comes straight
  // from the registers, so there is no input-to-output combinational path.
  always_comb begin
    in_ready  = (state == ST_ACC);
    out_valid = (state == ST_HOLD);
    out_sum   = acc;
    out_count = cnt;
    out_ovf   = ovf;
  end

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: three instances (default, ACC_W=18, N_TERMS=1),
// table-driven vectors, hand-written corner sequences and a randomized run
// against a transaction-level reference model.
module tb_prod_accum;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic        iv0, ir0, il0, ov0, or0, of0;
  logic [15:0] ip0;
  logic [23:0] os0;
  logic [3:0]  oc0;

  // Instance 1: ACC_W=18
  logic        iv1, ir1, il1, ov1, or1, of1;
  logic [15:0] ip1;
  logic [17:0] os1;
  logic [3:0]  oc1;

  // Instance 2: N_TERMS=1
  logic        iv2, ir2, il2, ov2, or2, of2;
  logic [15:0] ip2;
  logic [23:0] os2;
  logic [0:0]  oc2;

  prod_accum u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_prod(ip0),
    .in_last(il0), .out_valid(ov0), .out_ready(or0), .out_sum(os0),
    .out_count(oc0), .out_ovf(of0)
  );

  prod_accum #(.ACC_W(18)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_prod(ip1),
    .in_last(il1), .out_valid(ov1), .out_ready(or1), .out_sum(os1),
    .out_count(oc1), .out_ovf(of1)
  );

  prod_accum #(.N_TERMS(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_prod(ip2),
    .in_last(il2), .out_valid(ov2), .out_ready(or2), .out_sum(os2),
    .out_count(oc2), .out_ovf(of2)
  );

  int errors = 0;
  int nchk   = 0;

  typedef struct {
    logic [7:0][15:0] p;
    int               n;
    int               last_idx;
    longint           exp_sum;
    int               exp_cnt;
    bit               exp_ovf;
  } vec_t;

  typedef struct {
    longint s;
    int     c;
    bit     o;
  } res_t;

  vec_t tbl[5];
  res_t expq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present one product to instance 0 and wait (bounded) for its handshake.
  task automatic send0(input logic [15:0] p, input logic last);
    int t;
    t   = 0;
    iv0 = 1'b1;
    ip0 = p;
    il0 = last;
    while (!ir0 && t < 50) begin
      step();
      t++;
    end
    if (!ir0) begin
      nchk++;
      errors++;
      $display("FAIL send0_timeout: in_ready=%0b expected 1", ir0);
    end
    step();
    iv0 = 1'b0;
    il0 = 1'b0;
  endtask

  // Take the displayed result from instance 0.
  task automatic drain0();
    or0 = 1'b1;
    step();
    or0 = 1'b0;
  endtask

  initial begin
    logic [3:0] rdy_seq;
    longint     msum;
    int         mcnt;
    res_t       r;

    rst = 1'b1;
    iv0 = 0; ip0 = 0; il0 = 0; or0 = 0;
    iv1 = 0; ip1 = 0; il1 = 0; or1 = 0;
    iv2 = 0; ip2 = 0; il2 = 0; or2 = 0;

    tbl[0].p = {8{16'd65025}};
    tbl[0].n = 8; tbl[0].last_idx = -1;
    tbl[0].exp_sum = 520200; tbl[0].exp_cnt = 8; tbl[0].exp_ovf = 0;

    tbl[1].p = '0;
    tbl[1].p[0] = 16'd10; tbl[1].p[1] = 16'd20; tbl[1].p[2] = 16'd30;
    tbl[1].n = 3; tbl[1].last_idx = 2;
    tbl[1].exp_sum = 60; tbl[1].exp_cnt = 3; tbl[1].exp_ovf = 0;

    tbl[2].p = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[2].n = 8; tbl[2].last_idx = -1;
    tbl[2].exp_sum = 36; tbl[2].exp_cnt = 8; tbl[2].exp_ovf = 0;

    tbl[3].p = {8{16'hFFFF}};
    tbl[3].n = 4; tbl[3].last_idx = 3;
    tbl[3].exp_sum = 262140; tbl[3].exp_cnt = 4; tbl[3].exp_ovf = 0;

    tbl[4].p = '0;
    tbl[4].n = 1; tbl[4].last_idx = 0;
    tbl[4].exp_sum = 0; tbl[4].exp_cnt = 1; tbl[4].exp_ovf = 0;

    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", ov0, 0);
    chk("rst_in_ready", ir0, 1);
    chk("rst_sum", os0, 0);
    chk("rst_count", oc0, 0);
    chk("rst_ovf", of0, 0);
    chk("rst_u2_in_ready", ir2, 1);

    // Table vectors on the default instance
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        chk($sformatf("v%0d_no_early_out_%0d", v, i), ov0, 0);
        send0(tbl[v].p[i], (i == tbl[v].last_idx));
      end
      chk($sformatf("v%0d_latency", v), ov0, 1);
      chk($sformatf("v%0d_in_ready_hold", v), ir0, 0);
      chk($sformatf("v%0d_sum", v), os0, tbl[v].exp_sum);
      chk($sformatf("v%0d_count", v), oc0, tbl[v].exp_cnt);
      chk($sformatf("v%0d_ovf", v), of0, tbl[v].exp_ovf);
      drain0();
      chk($sformatf("v%0d_release", v), ov0, 0);
      chk($sformatf("v%0d_ready_again", v), ir0, 1);
    end

    // Backpressure: result held while out_ready=0 and in_valid=1
    send0(16'd100, 1'b0);
    send0(16'd200, 1'b1);
    iv0 = 1'b1; ip0 = 16'd999; il0 = 1'b0; or0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_in_ready_%0d", i), ir0, 0);
      chk($sformatf("bp_out_valid_%0d", i), ov0, 1);
      chk($sformatf("bp_sum_%0d", i), os0, 300);
      chk($sformatf("bp_count_%0d", i), oc0, 2);
      chk($sformatf("bp_ovf_%0d", i), of0, 0);
      step();
    end
    or0 = 1'b1;
    step();
    or0 = 1'b0;
    il0 = 1'b1;
    chk("bp_after_release_ready", ir0, 1);
    chk("bp_after_release_valid", ov0, 0);
    step();
    iv0 = 1'b0; il0 = 1'b0;
    chk("bp_next_valid", ov0, 1);
    chk("bp_next_sum", os0, 999);
    chk("bp_next_count", oc0, 1);
    drain0();

    // Reset mid-sum discards the partial sum
    for (int i = 0; i < 4; i++) send0(16'd1000 + 16'(i), 1'b0);
    chk("rst_mid_no_out", ov0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_out_valid", ov0, 0);
    chk("rst_mid_in_ready", ir0, 1);
    send0(16'd7, 1'b1);
    chk("rst_mid_valid", ov0, 1);
    chk("rst_mid_sum", os0, 7);
    chk("rst_mid_count", oc0, 1);
    drain0();

    // ACC_W=18: wrap and sticky overflow, cleared for the next sum
    iv1 = 1'b1; ip1 = 16'd65025; il1 = 1'b0; or1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w_in_ready_%0d", i), ir1, 1);
      step();
    end
    iv1 = 1'b0;
    chk("w_valid", ov1, 1);
    chk("w_sum", os1, 258056);
    chk("w_count", oc1, 8);
    chk("w_ovf", of1, 1);
    or1 = 1'b1;
    step();
    or1 = 1'b0;
    iv1 = 1'b1; ip1 = 16'd10;
    step();
    ip1 = 16'd20; il1 = 1'b1;
    step();
    iv1 = 1'b0; il1 = 1'b0;
    chk("w_next_valid", ov1, 1);
    chk("w_next_sum", os1, 30);
    chk("w_next_count", oc1, 2);
    chk("w_next_ovf", of1, 0);
    or1 = 1'b1;
    step();
    or1 = 1'b0;

    // N_TERMS=1: every product is its own sum
    iv2 = 1'b1; ip2 = 16'd5; or2 = 1'b1;
    rdy_seq[3] = ir2;
    step();
    rdy_seq[2] = ir2;
    chk("n1_first_valid", ov2, 1);
    chk("n1_first_sum", os2, 5);
    chk("n1_first_count", oc2, 1);
    ip2 = 16'd9;
    step();
    rdy_seq[1] = ir2;
    chk("n1_bubble_valid", ov2, 0);
    step();
    rdy_seq[0] = ir2;
    iv2 = 1'b0;
    chk("n1_second_valid", ov2, 1);
    chk("n1_second_sum", os2, 9);
    chk("n1_second_count", oc2, 1);
    chk("n1_ready_pattern", rdy_seq, 4'b1010);
    step();
    or2 = 1'b0;

    // Randomized run against a transaction-level model
    msum = 0;
    mcnt = 0;
    for (int cyc = 0; cyc < 600 + 40; cyc++) begin
      if (cyc < 600) begin
        iv0 = ($urandom_range(0, 3) != 0);
        ip0 = 16'($urandom);
        il0 = ($urandom_range(0, 5) == 0);
        or0 = ($urandom_range(0, 2) != 0);
      end else begin
        iv0 = 1'b0;
        il0 = 1'b0;
        or0 = 1'b1;
      end
      if (ov0 && or0) begin
        if (expq.size() == 0) begin
          nchk++;
          errors++;
          $display("FAIL rnd_unexpected_output: sum=%0d count=%0d expected none", os0, oc0);
        end else begin
          r = expq.pop_front();
          chk("rnd_sum", os0, r.s);
          chk("rnd_count", oc0, r.c);
          chk("rnd_ovf", of0, r.o);
        end
      end
      if (iv0 && ir0) begin
        msum += ip0;
        mcnt++;
        if (mcnt == 8 || il0) begin
          r.s = msum % (64'd1 << 24);
          r.c = mcnt;
          r.o = (msum >= (64'd1 << 24));
          expq.push_back(r);
          msum = 0;
          mcnt = 0;
        end
      end
      step();
    end
    chk("rnd_all_results_seen", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

endmodule
